// File: rtl/oled_pkg.sv
// SSD1306 driver shared definitions: FSM states, opcodes, init ROM, address window.
// Latency: none (declarations and pure functions only).
// Backpressure: n/a.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_INIT     = 3'd2,
        ST_ADDR     = 3'd3,
        ST_FETCH    = 3'd4,
        ST_PIXEL    = 3'd5,
        ST_GAP      = 3'd6
    } state_t;

    localparam logic [7:0] DISP_OFF     = 8'hAE;
    localparam logic [7:0] DISP_ON      = 8'hAF;
    localparam logic [7:0] SET_COL      = 8'h21;
    localparam logic [7:0] SET_PAGE     = 8'h22;
    localparam logic [7:0] SET_CONTRAST = 8'h81;

    localparam int INIT_LEN    = 25;
    localparam int PIXEL_BYTES = 1024;

    // Power-up command sequence, sent once after every reset.
    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = DISP_OFF;
            5'd1:    b = 8'hD5;
            5'd2:    b = 8'h80;
            5'd3:    b = 8'hA8;
            5'd4:    b = 8'h3F;
            5'd5:    b = 8'hD3;
            5'd6:    b = 8'h00;
            5'd7:    b = 8'h40;
            5'd8:    b = 8'h8D;
            5'd9:    b = 8'h14;
            5'd10:   b = 8'h20;
            5'd11:   b = 8'h00;
            5'd12:   b = 8'hA1;
            5'd13:   b = 8'hC8;
            5'd14:   b = 8'hDA;
            5'd15:   b = 8'h12;
            5'd16:   b = SET_CONTRAST;
            5'd17:   b = 8'hCF;
            5'd18:   b = 8'hD9;
            5'd19:   b = 8'hF1;
            5'd20:   b = 8'hDB;
            5'd21:   b = 8'h40;
            5'd22:   b = 8'hA4;
            5'd23:   b = 8'hA6;
            default: b = DISP_ON;
        endcase
        return b;
    endfunction

    // Full-screen column/page window sent ahead of every frame.
    function automatic logic [7:0] win_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SET_COL;
            3'd2:    b = 8'h7F;
            3'd3:    b = SET_PAGE;
            3'd5:    b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Single-byte SPI mode-0 transmitter: cs_n/sclk/mosi generation with CLK_DIV half-period divider.
// Latency: outputs change the clk after load_i; done_o is high in the last of 17*CLK_DIV busy clks.
// Backpressure: load_i is honoured only while idle; caller waits for done_o before the next load.
module spi_byte_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] dat_i,
    input  logic       dc_i,
    output logic       done_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_n_o,
    output logic       dc_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic             busy_q;
    logic [DIV_W-1:0] div_q;
    logic [4:0]       half_q;   // 0..15 shifting halves, 16 = cs_n high tail
    logic [7:0]       sh_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             cs_n_q;
    logic             dc_q;
    logic             last_div;

    assign last_div = (div_q == DIV_W'(CLK_DIV - 1));
    assign done_o   = busy_q && last_div && (half_q == 5'd16);
    assign sclk_o   = sclk_q;
    assign mosi_o   = mosi_q;
    assign cs_n_o   = cs_n_q;
    assign dc_o     = dc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            half_q <= '0;
            sh_q   <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_n_q <= 1'b1;
            dc_q   <= 1'b0;
        end else if (load_i && !busy_q) begin
            busy_q <= 1'b1;
            div_q  <= '0;
            half_q <= '0;
            sh_q   <= dat_i;
            mosi_q <= dat_i[7];
            sclk_q <= 1'b0;
            cs_n_q <= 1'b0;
            dc_q   <= dc_i;
        end else if (busy_q) begin
            if (last_div) begin
                div_q <= '0;
                if (half_q == 5'd16) begin
                    busy_q <= 1'b0;
                end else begin
                    half_q <= half_q + 5'd1;
                    if (half_q == 5'd15) begin
                        // final falling edge: release the bus for one half period
                        sclk_q <= 1'b0;
                        cs_n_q <= 1'b1;
                        mosi_q <= 1'b0;
                    end else if (!half_q[0]) begin
                        sclk_q <= 1'b1;
                    end else begin
                        // falling edge: present the next bit
                        sclk_q <= 1'b0;
                        sh_q   <= {sh_q[6:0], 1'b0};
                        mosi_q <= sh_q[6];
                    end
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1306 128x64 4-wire SPI driver: panel reset, init ROM, then endless address-window + 1024-pixel frames.
// Latency: data_in is latched 2 clks after byte_counter changes; each byte slot is 17*CLK_DIV+3 clks.
// Backpressure: none; the upstream must follow byte_counter with a 1-clk registered data_in.
// Option OLED_CONTRAST_EN: adds port contrast[7:0]; the window becomes 81 <contrast> 21 00 7F 22 00 07.
// Ports: clk/rst (sync, active-high), data_in pixel byte, byte_counter pixel index, oled_* panel pins,
//        frame_start 1-clk pulse on the load clk of pixel 0.
module oled_spi_driver
    import oled_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 270000,
    parameter int FRAME_GAP  = 0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef OLED_CONTRAST_EN
    input  logic [7:0] contrast,
`endif
    input  logic [7:0] data_in,
    output logic [9:0] byte_counter,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_cs_n,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       frame_start
);

`ifdef OLED_CONTRAST_EN
    localparam int ADDR_LEN = 8;
`else
    localparam int ADDR_LEN = 6;
`endif

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;          // slot phase: 0,1 settle, 2 load, 3 wait for done
    logic [4:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [9:0]  byte_counter_q, byte_counter_d;
    logic        first_q, first_d;    // next FETCH is pixel 0: counter already at 0
    logic        res_n_q, res_n_d;
    logic        frame_start_q, frame_start_d;

    logic        tx_load;
    logic [7:0]  tx_dat;
    logic        tx_dc;
    logic        tx_done;
    logic [7:0]  addr_dat;

`ifdef OLED_CONTRAST_EN
    logic [7:0]  contrast_q;

    always_comb begin
        addr_dat = win_byte(3'(idx_q - 5'd2));
        if (idx_q == 5'd0) addr_dat = SET_CONTRAST;
        if (idx_q == 5'd1) addr_dat = contrast_q;
    end

    // Contrast is frozen for a whole frame by sampling only when a window starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            contrast_q <= 8'hCF;
        end else if (state_d == ST_ADDR && state_q != ST_ADDR) begin
            contrast_q <= contrast;
        end
    end
`else
    assign addr_dat = win_byte(idx_q[2:0]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RST_LOW;
            ph_q           <= 2'd0;
            idx_q          <= 5'd0;
            cnt_q          <= 32'd0;
            byte_counter_q <= 10'd0;
            first_q        <= 1'b0;
            res_n_q        <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ph_q           <= ph_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            byte_counter_q <= byte_counter_d;
            first_q        <= first_d;
            res_n_q        <= res_n_d;
            frame_start_q  <= frame_start_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ph_d           = ph_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        byte_counter_d = byte_counter_q;
        first_d        = first_q;
        res_n_d        = res_n_q;
        frame_start_d  = 1'b0;
        tx_load        = 1'b0;
        tx_dat         = 8'h00;
        tx_dc          = 1'b0;

        case (state_q)
            ST_RST_LOW: begin
                res_n_d = 1'b0;
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    cnt_d   = 32'd0;
                    res_n_d = 1'b1;
                    state_d = ST_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    // First init byte launches from the final wait clk so CS falls as the wait expires.
                    cnt_d   = 32'd0;
                    tx_load = 1'b1;
                    tx_dat  = init_rom(5'd0);
                    idx_d   = 5'd0;
                    ph_d    = 2'd3;
                    state_d = ST_INIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                case (ph_q)
                    2'd2: begin
                        tx_load = 1'b1;
                        tx_dat  = init_rom(idx_q);
                        ph_d    = 2'd3;
                    end
                    2'd3: begin
                        if (tx_done) begin
                            ph_d = 2'd0;
                            if (idx_q == 5'(INIT_LEN - 1)) begin
                                idx_d   = 5'd0;
                                state_d = ST_ADDR;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                    end
                    default: ph_d = ph_q + 2'd1;
                endcase
            end
            ST_ADDR: begin
                case (ph_q)
                    2'd2: begin
                        tx_load = 1'b1;
                        tx_dat  = addr_dat;
                        ph_d    = 2'd3;
                    end
                    2'd3: begin
                        if (tx_done) begin
                            ph_d = 2'd0;
                            if (idx_q == 5'(ADDR_LEN - 1)) begin
                                idx_d   = 5'd0;
                                first_d = 1'b1;
                                state_d = ST_FETCH;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                    end
                    default: ph_d = ph_q + 2'd1;
                endcase
            end
            ST_FETCH: begin
                if (!first_q) byte_counter_d = byte_counter_q + 10'd1;
                first_d = 1'b0;
                ph_d    = 2'd1;
                state_d = ST_PIXEL;
            end
            ST_PIXEL: begin
                case (ph_q)
                    2'd2: begin
                        // two clks after the counter update: upstream data is now valid
                        tx_load       = 1'b1;
                        tx_dat        = data_in;
                        tx_dc         = 1'b1;
                        frame_start_d = (byte_counter_q == 10'd0);
                        ph_d          = 2'd3;
                    end
                    2'd3: begin
                        if (tx_done) begin
                            ph_d = 2'd0;
                            if (byte_counter_q == 10'(PIXEL_BYTES - 1)) begin
                                byte_counter_d = 10'd0;
                                cnt_d          = 32'd0;
                                state_d        = (FRAME_GAP == 0) ? ST_ADDR : ST_GAP;
                            end else begin
                                state_d = ST_FETCH;
                            end
                        end
                    end
                    default: ph_d = 2'd2;
                endcase
            end
            ST_GAP: begin
                if (cnt_q == 32'(FRAME_GAP - 1)) begin
                    cnt_d   = 32'd0;
                    ph_d    = 2'd0;
                    state_d = ST_ADDR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_RST_LOW;
        endcase
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (tx_load),
        .dat_i  (tx_dat),
        .dc_i   (tx_dc),
        .done_o (tx_done),
        .sclk_o (oled_sclk),
        .mosi_o (oled_mosi),
        .cs_n_o (oled_cs_n),
        .dc_o   (oled_dc)
    );

    assign byte_counter = byte_counter_q;
    assign oled_res_n   = res_n_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Bench for oled_spi_driver: decodes the SPI bus and compares against a byte-stream model.
// Latency: n/a.
// Backpressure: n/a.
module tb_oled_spi_driver;

    localparam int CLK_DIV    = 2;
    localparam int RST_CYCLES = 8;
    localparam int FRAME_GAP  = 5;
`ifdef OLED_CONTRAST_EN
    localparam int WIN = 8;
`else
    localparam int WIN = 6;
`endif
    localparam int FB        = WIN + 1024;
    localparam int FRAME_LEN = FB * (17 * CLK_DIV + 3) + FRAME_GAP;

    localparam logic [7:0] INIT_TBL [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    localparam logic [7:0] WIN_TBL [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [9:0] byte_counter;
    logic       oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_res_n, frame_start;
`ifdef OLED_CONTRAST_EN
    logic [7:0] contrast;
`endif

    oled_spi_driver #(
        .CLK_DIV    (CLK_DIV),
        .RST_CYCLES (RST_CYCLES),
        .FRAME_GAP  (FRAME_GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef OLED_CONTRAST_EN
        .contrast     (contrast),
`endif
        .data_in      (data_in),
        .byte_counter (byte_counter),
        .oled_sclk    (oled_sclk),
        .oled_mosi    (oled_mosi),
        .oled_cs_n    (oled_cs_n),
        .oled_dc      (oled_dc),
        .oled_res_n   (oled_res_n),
        .frame_start  (frame_start)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] key     = 8'h00;   // upstream returns byte_counter[7:0] ^ key
    logic [7:0] c_first = 8'h40;   // contrast expected in the first window after reset

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected k-th SPI byte after reset as {dc, data}.
    function automatic logic [8:0] exp_byte(input int k);
        int         j, f;
        logic [7:0] b;
        if (k < 25) return {1'b0, INIT_TBL[k]};
        j = (k - 25) % FB;
        f = (k - 25) / FB;
`ifdef OLED_CONTRAST_EN
        if (j == 0) return {1'b0, 8'h81};
        if (j == 1) return {1'b0, (f == 0) ? c_first : 8'h7F};
        if (j < WIN) return {1'b0, WIN_TBL[j - 2]};
`else
        if (f < 0) return 9'h1FF;
        if (j < WIN) return {1'b0, WIN_TBL[j]};
`endif
        b = 8'((j - WIN) % 256);
        return {1'b1, b ^ key};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream image controller: one-register latency behind byte_counter.
    initial begin
        logic [9:0] bc_s;
        data_in = 8'h00;
        forever begin
            @(negedge clk);
            bc_s = byte_counter;
            @(posedge clk);
            #1;
            data_in = bc_s[7:0] ^ key;
        end
    end

    // Bus monitor
    int         cyc = 0, nbytes = 0, bitcnt = 0, prev_bc = 0, last_fs = -1;
    int         n_periods = 0, wraps = 0, dc_glitch = 0;
    logic       prev_sclk = 1'b0;
    logic       byte_dc = 1'b0;
    logic [7:0] sh = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bitcnt    = 0;
            nbytes    = 0;
            prev_sclk = 1'b0;
            prev_bc   = 0;
            last_fs   = -1;
        end else begin
            if (oled_sclk && !prev_sclk) begin
                if (bitcnt == 0) byte_dc = oled_dc;
                else if (oled_dc != byte_dc) dc_glitch++;
                sh = {sh[6:0], oled_mosi};
                bitcnt++;
                if (bitcnt == 8) begin
                    check($sformatf("byte%0d", nbytes), {23'd0, byte_dc, sh}, {23'd0, exp_byte(nbytes)});
                    nbytes++;
                    bitcnt = 0;
                end
            end
            prev_sclk = oled_sclk;
            if (frame_start) begin
                check("fs_pos", (nbytes < 25) ? 32'hFFFF : 32'((nbytes - 25) % FB), 32'(WIN));
                if (last_fs >= 0) begin
                    check("frame_period", 32'(cyc - last_fs), 32'(FRAME_LEN));
                    n_periods++;
                end
                last_fs = cyc;
            end
            if (int'(byte_counter) != prev_bc) begin
                check("bc_step", 32'(byte_counter), 32'((prev_bc + 1) % 1024));
                if (prev_bc == 1023) wraps++;
                prev_bc = int'(byte_counter);
            end
        end
    end

    initial begin
        int cnt;
        int target;
        rst = 1'b1;
`ifdef OLED_CONTRAST_EN
        contrast = 8'h40;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk", 32'(oled_sclk), 32'd0);
        check("rst_mosi", 32'(oled_mosi), 32'd0);
        check("rst_cs_n", 32'(oled_cs_n), 32'd1);
        check("rst_dc", 32'(oled_dc), 32'd0);
        check("rst_res_n", 32'(oled_res_n), 32'd0);
        check("rst_bc", 32'(byte_counter), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        rst = 1'b0;

        cnt = 0;
        while (oled_res_n !== 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("res_n_low_clks", cnt, RST_CYCLES);
        cnt = 0;
        while (oled_cs_n !== 1'b0 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("first_cs_fall_clks", cnt, RST_CYCLES);

        // Run through frame 0 into pixel byte 500 of frame 1, bit 3.
        target = 25 + FB + WIN + 500;
        cnt = 0;
        while (!(nbytes == target && bitcnt == 3) && cnt < 90000) begin
            @(negedge clk);
            cnt++;
`ifdef OLED_CONTRAST_EN
            if (nbytes == 25 + WIN + 100) contrast = 8'h7F;
`endif
        end
        check("reach_px500_bit3", 32'(nbytes == target && bitcnt == 3), 32'd1);
        check("frame_period_seen", n_periods, 1);
        check("bc_wrap_seen", wraps, 1);

        rst = 1'b1;
        key = 8'($urandom_range(1, 255));
        c_first = 8'h7F;
        @(negedge clk);
        check("abort_cs_n", 32'(oled_cs_n), 32'd1);
        check("abort_sclk", 32'(oled_sclk), 32'd0);
        check("abort_mosi", 32'(oled_mosi), 32'd0);
        check("abort_res_n", 32'(oled_res_n), 32'd0);
        check("abort_bc", 32'(byte_counter), 32'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rst = 1'b0;

        target = 25 + WIN + 64;
        cnt = 0;
        while (nbytes < target && cnt < 10000) begin
            @(negedge clk);
            cnt++;
        end
        check("reinit_progress", 32'(nbytes >= target), 32'd1);
        check("dc_stable", dc_glitch, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
